// File: rtl/mul_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// The master side issues start with operands and the slave side returns the product.
interface mul_seq_ctrl_if #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
);
  logic                       start;
  logic [WIDTH_A-1:0]         A;
  logic [WIDTH_B-1:0]         B;
  logic                       busy;
  logic                       done;
  logic [WIDTH_A+WIDTH_B-1:0] P;
  logic [WIDTH_A-1:0]         Y;
  logic                       C_out;

  modport master (
    output start, A, B,
    input  busy, done, P, Y, C_out
  );

  modport slave (
    input  start, A, B,
    output busy, done, P, Y, C_out
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Radix-4 sequential unsigned multiplier, one digit of B per cycle.
// P is registered and only updates on completion; Y/C_out feed the ALU mux.
module mul_seq_ctrl #(
  parameter int WIDTH_A = 4,
  parameter int WIDTH_B = 4
) (
  input logic           clk,
  input logic           rst,
  mul_seq_ctrl_if.slave bus
);
  localparam int NDIG = WIDTH_B / 2;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int PW   = WIDTH_A + WIDTH_B;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // a_sh holds a_r << 2k and b_sh holds b_r >> 2k, so the
  // current digit is always b_sh[1:0] with no variable indexing.
  logic [PW-1:0]      a_sh;
  logic [WIDTH_B-1:0] b_sh;
  logic [PW-1:0]      acc;
  logic [PW-1:0]      acc_nxt;
  logic [PW-1:0]      pp;
  logic [PW-1:0]      p_r;
  logic [KW-1:0]      k;
  logic [1:0]         d;
  logic               last;
  logic               accept;

  assign last   = (k == KW'(NDIG - 1));
  assign accept = (state != RUN) && bus.start;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = bus.start ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  always_comb begin
    d       = b_sh[1:0];
    pp      = '0;
    if (d[0]) pp = pp + a_sh;
    if (d[1]) pp = pp + (a_sh << 1);
    acc_nxt = acc + pp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      k    <= '0;
      p_r  <= '0;
    end else if (accept) begin
      a_sh <= PW'(bus.A);
      b_sh <= bus.B;
      acc  <= '0;
      k    <= '0;
    end else if (state == RUN) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << 2;
      b_sh <= b_sh >> 2;
      if (last) p_r <= acc_nxt;
      else      k   <= k + KW'(1);
    end
  end

  assign bus.P     = p_r;
  assign bus.Y     = p_r[WIDTH_A-1:0];
  assign bus.C_out = |p_r[PW-1:WIDTH_A];
endmodule
